// File: rtl/alu_operand_stager_pkg.sv
// rtl/alu_operand_stager_pkg.sv - token types (pkg_en) and shared ALU front-end constants (pkg_alu)
// FTk_t carries the optional id field only when EXTEND is defined.
package pkg_en;
  localparam int W_DATA = 32;
  localparam int W_ID   = 8;

  typedef struct packed {
    logic              v;
    logic              a;
    logic              c;
    logic              r;
`ifdef EXTEND
    logic [W_ID-1:0]   i;
`endif
    logic [W_DATA-1:0] d;
  } FTk_t;

  localparam int W_FTK_CTRL = $bits(FTk_t) - W_DATA;

  typedef struct packed {
    logic t;
    logic v;
    logic c;
    logic n;
  } BTk_t;
endpackage

package pkg_alu;
  localparam int DEPTH_FIFO_DEF = 4;

  // One slot stays free for a token already in flight when nack rises.
  function automatic int nack_threshold(input int depth);
    return depth - 1;
  endfunction
endpackage

// File: rtl/token_fifo.sv
// rtl/token_fifo.sv - shallow token FIFO with flush and overflow detect
// Flush wins over push and pop; a push on a full FIFO is accepted only if a pop frees the slot.
module token_fifo
  import pkg_en::*;
#(
  parameter int WIDTH_DATA = W_DATA,
  parameter int DEPTH_FIFO = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               push_i,
  input  logic [WIDTH_DATA+W_FTK_CTRL-1:0]   data_i,
  input  logic                               pop_i,
  input  logic                               flush_i,
  output logic [WIDTH_DATA+W_FTK_CTRL-1:0]   head_o,
  output logic [$clog2(DEPTH_FIFO):0]        count_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic                               overflow_o
);
  localparam int PTR_W = $clog2(DEPTH_FIFO);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = WIDTH_DATA + W_FTK_CTRL;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH_FIFO);

  logic [ENT_W-1:0] mem_q [DEPTH_FIFO];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign overflow_o = push_i & ~do_push & ~flush_i;
  assign head_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge clock) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/alu_operand_stager.sv
// rtl/alu_operand_stager.sv - buffers A/B operand token streams and issues aligned pairs to an ALU
// Optional OPERAND_STICKY_EN: a B token with a=1,r=0 is held as a reusable B operand until a B token with r=1.
module alu_operand_stager
  import pkg_en::*;
  import pkg_alu::*;
#(
  parameter int WIDTH_DATA = W_DATA,
  parameter int DEPTH_FIFO = DEPTH_FIFO_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic I_En,
  input  FTk_t I_OperandA,
  input  FTk_t I_OperandB,
  output BTk_t O_BTk_A,
  output BTk_t O_BTk_B,
  output FTk_t O_OperandA,
  output FTk_t O_OperandB,
  input  BTk_t I_BTk,
  output logic O_Err
);
  localparam int CNT_W = $clog2(DEPTH_FIFO) + 1;
  localparam int ENT_W = WIDTH_DATA + W_FTK_CTRL;
  localparam logic [CNT_W-1:0] NACK_CNT = CNT_W'(nack_threshold(DEPTH_FIFO));

  logic             flush, issue;
  logic             push_a, push_b, pop_a, pop_b;
  logic [ENT_W-1:0] head_a_raw, head_b_raw;
  FTk_t             head_a, head_b, fifo_head_b;
  logic             head_b_valid;
  logic [CNT_W-1:0] count_a, count_b;
  logic             full_a, full_b, empty_a, empty_b, ovf_a, ovf_b;
  logic             err_q, err_d;
  logic             unused_full;

  assign flush       = I_BTk.t;
  assign head_a      = FTk_t'(head_a_raw);
  assign fifo_head_b = FTk_t'(head_b_raw);
  assign unused_full = full_a ^ full_b;
  assign push_a      = I_OperandA.v;
  assign pop_a       = issue;
  assign issue       = I_En & ~empty_a & head_b_valid & ~I_BTk.n;

`ifdef OPERAND_STICKY_EN
  FTk_t stk_q, stk_d;
  logic stk_v_q, stk_v_d;
  logic b_capture;

  assign b_capture = I_OperandB.v & I_OperandB.a & ~I_OperandB.r;

  always_comb begin
    stk_d   = stk_q;
    stk_v_d = stk_v_q;
    if (flush) begin
      stk_v_d = 1'b0;
    end else if (b_capture) begin
      stk_d   = I_OperandB;
      stk_v_d = 1'b1;
    end else if (I_OperandB.v && I_OperandB.r) begin
      stk_v_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stk_q   <= '0;
      stk_v_q <= 1'b0;
    end else begin
      stk_q   <= stk_d;
      stk_v_q <= stk_v_d;
    end
  end

  assign push_b       = I_OperandB.v & ~b_capture;
  assign head_b       = stk_v_q ? stk_q : fifo_head_b;
  assign head_b_valid = stk_v_q | ~empty_b;
  assign pop_b        = issue & ~stk_v_q;
`else
  assign push_b       = I_OperandB.v;
  assign head_b       = fifo_head_b;
  assign head_b_valid = ~empty_b;
  assign pop_b        = issue;
`endif

  token_fifo #(.WIDTH_DATA(WIDTH_DATA), .DEPTH_FIFO(DEPTH_FIFO)) u_fifo_a (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push_a),
    .data_i     (I_OperandA),
    .pop_i      (pop_a),
    .flush_i    (flush),
    .head_o     (head_a_raw),
    .count_o    (count_a),
    .full_o     (full_a),
    .empty_o    (empty_a),
    .overflow_o (ovf_a)
  );

  token_fifo #(.WIDTH_DATA(WIDTH_DATA), .DEPTH_FIFO(DEPTH_FIFO)) u_fifo_b (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push_b),
    .data_i     (I_OperandB),
    .pop_i      (pop_b),
    .flush_i    (flush),
    .head_o     (head_b_raw),
    .count_o    (count_b),
    .full_o     (full_b),
    .empty_o    (empty_b),
    .overflow_o (ovf_b)
  );

  always_comb begin
    O_OperandA   = head_a;
    O_OperandA.v = issue;
    O_OperandB   = head_b;
    O_OperandB.v = issue;
    O_BTk_A      = '{t: I_BTk.t, v: I_BTk.v, c: I_BTk.c, n: (count_a >= NACK_CNT)};
    O_BTk_B      = '{t: I_BTk.t, v: I_BTk.v, c: I_BTk.c, n: (count_b >= NACK_CNT)};
  end

  assign err_d = err_q | ovf_a | ovf_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign O_Err = err_q;
endmodule

// File: tb/tb_alu_operand_stager.sv
// tb/tb_alu_operand_stager.sv - directed self-checking bench for alu_operand_stager
// Sticky-operand scenario runs only when OPERAND_STICKY_EN is defined.
module tb_alu_operand_stager;
  import pkg_en::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic I_En  = 1'b0;
  FTk_t I_OperandA = '0;
  FTk_t I_OperandB = '0;
  BTk_t I_BTk = '0;
  BTk_t O_BTk_A, O_BTk_B;
  FTk_t O_OperandA, O_OperandB;
  logic O_Err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alu_operand_stager u_dut (
    .clock      (clock),
    .reset      (reset),
    .I_En       (I_En),
    .I_OperandA (I_OperandA),
    .I_OperandB (I_OperandB),
    .O_BTk_A    (O_BTk_A),
    .O_BTk_B    (O_BTk_B),
    .O_OperandA (O_OperandA),
    .O_OperandB (O_OperandB),
    .I_BTk      (I_BTk),
    .O_Err      (O_Err)
  );

  function automatic FTk_t tok(input logic a, input logic r, input logic [31:0] d);
    FTk_t t;
    t   = '0;
    t.v = 1'b1;
    t.a = a;
    t.r = r;
    t.d = d;
    return t;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    I_OperandA = '0;
    I_OperandB = '0;
    I_BTk      = '0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (O_OperandA.v !== 1'b0) begin bad++; $display("FAIL reset_va got=%b exp=0", O_OperandA.v); end
    total++; if (O_OperandB.v !== 1'b0) begin bad++; $display("FAIL reset_vb got=%b exp=0", O_OperandB.v); end
    total++; if (O_BTk_A.n !== 1'b0) begin bad++; $display("FAIL reset_na got=%b exp=0", O_BTk_A.n); end
    total++; if (O_Err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", O_Err); end
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_pairing();
    I_En = 1'b1;
    I_OperandA = tok(1'b0, 1'b0, 32'd5);
    I_OperandB = tok(1'b0, 1'b0, 32'd3);
    tick();
    idle();
    #1;
    total++; if (O_OperandA.v !== 1'b1) begin bad++; $display("FAIL pair_va got=%b exp=1", O_OperandA.v); end
    total++; if (O_OperandA.d !== 32'd5) begin bad++; $display("FAIL pair_da got=%0d exp=5", O_OperandA.d); end
    total++; if (O_OperandB.v !== 1'b1) begin bad++; $display("FAIL pair_vb got=%b exp=1", O_OperandB.v); end
    total++; if (O_OperandB.d !== 32'd3) begin bad++; $display("FAIL pair_db got=%0d exp=3", O_OperandB.d); end
    tick();
    total++; if (u_dut.count_a !== 3'd0) begin bad++; $display("FAIL pair_cnta got=%0d exp=0", u_dut.count_a); end
    total++; if (u_dut.count_b !== 3'd0) begin bad++; $display("FAIL pair_cntb got=%0d exp=0", u_dut.count_b); end
    total++; if (O_OperandA.v !== 1'b0) begin bad++; $display("FAIL pair_va_after got=%b exp=0", O_OperandA.v); end
  endtask

  task automatic test_backpressure();
    int exp_cnt;
    I_En = 1'b0;
    for (int i = 0; i < 5; i++) begin
      I_OperandA = tok(1'b0, 1'b0, 32'd11 + i);
      tick();
      idle();
      #1;
      exp_cnt = (i < 4) ? i + 1 : 4;
      total++; if (u_dut.count_a !== exp_cnt[2:0]) begin bad++; $display("FAIL bp_cnt[%0d] got=%0d exp=%0d", i, u_dut.count_a, exp_cnt); end
      total++; if (O_BTk_A.n !== (exp_cnt >= 3)) begin bad++; $display("FAIL bp_nack[%0d] got=%b exp=%b", i, O_BTk_A.n, exp_cnt >= 3); end
      total++; if (O_Err !== (i == 4)) begin bad++; $display("FAIL bp_err[%0d] got=%b exp=%b", i, O_Err, i == 4); end
    end
    total++; if (O_BTk_B.n !== 1'b0) begin bad++; $display("FAIL bp_nackb got=%b exp=0", O_BTk_B.n); end
    total++; if (O_OperandA.d !== 32'd11) begin bad++; $display("FAIL bp_head got=%0d exp=11", O_OperandA.d); end
    I_BTk.t = 1'b1;
    tick();
    idle();
    #1;
    total++; if (u_dut.count_a !== 3'd0) begin bad++; $display("FAIL bp_flush_cnt got=%0d exp=0", u_dut.count_a); end
    total++; if (O_Err !== 1'b1) begin bad++; $display("FAIL bp_err_kept got=%b exp=1", O_Err); end
  endtask

  task automatic test_reset_mid();
    I_En = 1'b0;
    I_OperandA = tok(1'b0, 1'b0, 32'd21);
    I_OperandB = tok(1'b0, 1'b0, 32'd22);
    tick();
    I_OperandA = tok(1'b0, 1'b0, 32'd23);
    I_OperandB = tok(1'b0, 1'b0, 32'd24);
    tick();
    idle();
    I_En = 1'b1;
    #1;
    total++; if (O_OperandA.v !== 1'b1) begin bad++; $display("FAIL rm_pre_v got=%b exp=1", O_OperandA.v); end
    total++; if (O_Err !== 1'b1) begin bad++; $display("FAIL rm_pre_err got=%b exp=1", O_Err); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (O_OperandA.v !== 1'b0) begin bad++; $display("FAIL rm_va got=%b exp=0", O_OperandA.v); end
    total++; if (O_OperandB.v !== 1'b0) begin bad++; $display("FAIL rm_vb got=%b exp=0", O_OperandB.v); end
    total++; if (O_Err !== 1'b0) begin bad++; $display("FAIL rm_err got=%b exp=0", O_Err); end
    total++; if (u_dut.count_a !== 3'd0) begin bad++; $display("FAIL rm_cnt got=%0d exp=0", u_dut.count_a); end
    @(negedge clock);
    reset = 1'b1;
    I_En  = 1'b0;
  endtask

  task automatic test_flush();
    I_En = 1'b0;
    tick();
    I_OperandA = tok(1'b0, 1'b0, 32'd20);
    I_OperandB = tok(1'b0, 1'b0, 32'd21);
    tick();
    I_OperandA = tok(1'b0, 1'b0, 32'd9);
    I_OperandB = '0;
    I_BTk = '{t: 1'b1, v: 1'b1, c: 1'b1, n: 1'b0};
    #1;
    total++; if (O_BTk_A.t !== 1'b1) begin bad++; $display("FAIL fl_ta got=%b exp=1", O_BTk_A.t); end
    total++; if (O_BTk_B.t !== 1'b1) begin bad++; $display("FAIL fl_tb got=%b exp=1", O_BTk_B.t); end
    total++; if (O_BTk_A.v !== 1'b1) begin bad++; $display("FAIL fl_va got=%b exp=1", O_BTk_A.v); end
    total++; if (O_BTk_B.c !== 1'b1) begin bad++; $display("FAIL fl_cb got=%b exp=1", O_BTk_B.c); end
    tick();
    idle();
    #1;
    total++; if (u_dut.count_a !== 3'd0) begin bad++; $display("FAIL fl_cnta got=%0d exp=0", u_dut.count_a); end
    total++; if (u_dut.count_b !== 3'd0) begin bad++; $display("FAIL fl_cntb got=%0d exp=0", u_dut.count_b); end
    total++; if (O_Err !== 1'b0) begin bad++; $display("FAIL fl_err got=%b exp=0", O_Err); end
    I_En = 1'b1;
    I_OperandA = tok(1'b0, 1'b0, 32'd30);
    I_OperandB = tok(1'b0, 1'b0, 32'd31);
    tick();
    idle();
    #1;
    total++; if (O_OperandA.d !== 32'd30) begin bad++; $display("FAIL fl_head got=%0d exp=30", O_OperandA.d); end
    tick();
  endtask

  task automatic test_stall();
    I_En = 1'b0;
    I_OperandA = tok(1'b0, 1'b0, 32'd40);
    I_OperandB = tok(1'b0, 1'b0, 32'd50);
    tick();
    I_OperandA = tok(1'b0, 1'b0, 32'd41);
    I_OperandB = tok(1'b0, 1'b0, 32'd51);
    tick();
    idle();
    I_En = 1'b1;
    I_BTk.n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (O_OperandA.v !== 1'b0) begin bad++; $display("FAIL st_va[%0d] got=%b exp=0", i, O_OperandA.v); end
      total++; if (O_OperandB.v !== 1'b0) begin bad++; $display("FAIL st_vb[%0d] got=%b exp=0", i, O_OperandB.v); end
      total++; if (u_dut.count_a !== 3'd2) begin bad++; $display("FAIL st_cnt[%0d] got=%0d exp=2", i, u_dut.count_a); end
      tick();
    end
    I_BTk.n = 1'b0;
    #1;
    total++; if (O_OperandA.v !== 1'b1 || O_OperandA.d !== 32'd40 || O_OperandB.d !== 32'd50) begin bad++; $display("FAIL st_pair0 got=%b/%0d/%0d exp=1/40/50", O_OperandA.v, O_OperandA.d, O_OperandB.d); end
    tick();
    total++; if (O_OperandA.v !== 1'b1 || O_OperandA.d !== 32'd41 || O_OperandB.d !== 32'd51) begin bad++; $display("FAIL st_pair1 got=%b/%0d/%0d exp=1/41/51", O_OperandA.v, O_OperandA.d, O_OperandB.d); end
    tick();
    total++; if (O_OperandA.v !== 1'b0 || u_dut.count_a !== 3'd0) begin bad++; $display("FAIL st_drain got=%b/%0d exp=0/0", O_OperandA.v, u_dut.count_a); end
  endtask

  task automatic test_back_to_back();
    I_En = 1'b1;
    for (int i = 0; i < 4; i++) begin
      I_OperandA = tok(1'b0, 1'b0, 32'd60 + i);
      I_OperandB = tok(1'b0, 1'b0, 32'd70 + i);
      tick();
      total++; if (O_OperandA.v !== 1'b1 || O_OperandA.d !== 32'd60 + i || O_OperandB.d !== 32'd70 + i) begin bad++; $display("FAIL b2b[%0d] got=%b/%0d/%0d exp=1/%0d/%0d", i, O_OperandA.v, O_OperandA.d, O_OperandB.d, 60 + i, 70 + i); end
    end
    idle();
    tick();
    total++; if (u_dut.count_a !== 3'd0 || u_dut.count_b !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d/%0d exp=0/0", u_dut.count_a, u_dut.count_b); end
  endtask

  task automatic test_full_pushpop();
    I_En = 1'b0;
    for (int i = 0; i < 4; i++) begin
      I_OperandA = tok(1'b0, 1'b0, 32'd80 + i);
      I_OperandB = tok(1'b0, 1'b0, 32'd90 + i);
      tick();
    end
    total++; if (u_dut.count_a !== 3'd4) begin bad++; $display("FAIL fp_full got=%0d exp=4", u_dut.count_a); end
    I_En = 1'b1;
    I_OperandA = tok(1'b0, 1'b0, 32'd99);
    I_OperandB = tok(1'b0, 1'b0, 32'd98);
    #1;
    total++; if (O_OperandA.v !== 1'b1 || O_OperandA.d !== 32'd80) begin bad++; $display("FAIL fp_issue got=%b/%0d exp=1/80", O_OperandA.v, O_OperandA.d); end
    tick();
    idle();
    I_En = 1'b0;
    #1;
    total++; if (u_dut.count_a !== 3'd4) begin bad++; $display("FAIL fp_cnt got=%0d exp=4", u_dut.count_a); end
    total++; if (O_Err !== 1'b0) begin bad++; $display("FAIL fp_err got=%b exp=0", O_Err); end
    total++; if (O_OperandA.d !== 32'd81) begin bad++; $display("FAIL fp_head got=%0d exp=81", O_OperandA.d); end
    I_BTk.t = 1'b1;
    tick();
    idle();
  endtask

`ifdef OPERAND_STICKY_EN
  task automatic test_sticky();
    I_En = 1'b1;
    I_OperandB = tok(1'b1, 1'b0, 32'd7);
    tick();
    I_OperandB = '0;
    I_OperandA = tok(1'b0, 1'b0, 32'd1);
    tick();
    total++; if (O_OperandA.v !== 1'b1 || O_OperandA.d !== 32'd1 || O_OperandB.d !== 32'd7) begin bad++; $display("FAIL sk_p0 got=%b/%0d/%0d exp=1/1/7", O_OperandA.v, O_OperandA.d, O_OperandB.d); end
    I_OperandA = tok(1'b0, 1'b0, 32'd2);
    tick();
    total++; if (O_OperandA.v !== 1'b1 || O_OperandA.d !== 32'd2 || O_OperandB.d !== 32'd7) begin bad++; $display("FAIL sk_p1 got=%b/%0d/%0d exp=1/2/7", O_OperandA.v, O_OperandA.d, O_OperandB.d); end
    I_OperandA = tok(1'b0, 1'b0, 32'd3);
    tick();
    total++; if (O_OperandA.v !== 1'b1 || O_OperandA.d !== 32'd3 || O_OperandB.d !== 32'd7) begin bad++; $display("FAIL sk_p2 got=%b/%0d/%0d exp=1/3/7", O_OperandA.v, O_OperandA.d, O_OperandB.d); end
    total++; if (u_dut.count_b !== 3'd0) begin bad++; $display("FAIL sk_cntb got=%0d exp=0", u_dut.count_b); end
    I_OperandA = '0;
    I_OperandB = tok(1'b0, 1'b1, 32'd4);
    tick();
    I_OperandB = '0;
    I_OperandA = tok(1'b0, 1'b0, 32'd10);
    tick();
    idle();
    #1;
    total++; if (O_OperandA.v !== 1'b1 || O_OperandA.d !== 32'd10 || O_OperandB.d !== 32'd4) begin bad++; $display("FAIL sk_p3 got=%b/%0d/%0d exp=1/10/4", O_OperandA.v, O_OperandA.d, O_OperandB.d); end
    tick();
    total++; if (O_OperandA.v !== 1'b0 || u_dut.count_b !== 3'd0) begin bad++; $display("FAIL sk_drain got=%b/%0d exp=0/0", O_OperandA.v, u_dut.count_b); end
  endtask
`endif

  initial begin
    test_reset();
    test_pairing();
    test_backpressure();
    test_reset_mid();
    test_flush();
    test_stall();
    test_back_to_back();
    test_full_pushpop();
`ifdef OPERAND_STICKY_EN
    test_sticky();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
